aes_subword_seq: RTL

Parametrised, multi-cycle AES SubWord unit: applies the forward or inverse AES SBox to each byte of a 32-bit source word using NSBOX shared instances of the team's `aes_sbox` primitive. It time-multiplexes the four byte lanes over 4/NSBOX beats, which trades latency for SBox area. It sits behind the scalar-crypto instruction decode as the execution unit for the AES SubWord-class instructions, using the core's valid/ready convention. Inputs to idle SBoxes are forced to zero, so no operand data toggles SBox logic outside an active beat.

---
 rtl/aes_subword_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aes_subword_seq.sv
// Multi-cycle AES SubWord unit: forward/inverse SBox over four byte lanes using
// NSBOX shared SBox instances, time-multiplexed across 4/NSBOX beats.

module aes_sbox (
  input  logic [7:0] in_i,
  input  logic       inv_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the SBox requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned s);
    return (x << s) | (x >> (8 - s));
  endfunction

  logic [7:0] inv_aff;

  always_comb begin
    inv_aff = rotl(in_i, 1) ^ rotl(in_i, 3) ^ rotl(in_i, 6) ^ 8'h05;
    if (inv_i) begin
      out_o = gf_inv(inv_aff);
    end else begin
      out_o = gf_inv(in_i);
      out_o = out_o ^ rotl(out_o, 1) ^ rotl(out_o, 2) ^ rotl(out_o, 3)
            ^ rotl(out_o, 4) ^ 8'h63;
    end
  end

endmodule

module aes_subword_seq #(
  parameter int unsigned NSBOX = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic        dec,
  input  logic [31:0] rs1,
  output logic        ready,
  output logic        busy,
  output logic [31:0] rd
);

  localparam int unsigned BEATS = 4 / NSBOX;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4) begin : g_bad_nsbox
    $error("aes_subword_seq: NSBOX must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q;
  logic [BW-1:0]       beat_q;
  logic [31:0]         op_q;
  logic                dec_q;
  logic [31:0]         res_q;
  logic [31:0]         res_d;
  logic                ready_q;
  logic                busy_q;
  logic [NSBOX*8-1:0]  sbox_in;
  logic [NSBOX*8-1:0]  sbox_out;
  logic                sbox_inv;

  for (genvar j = 0; j < NSBOX; j++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (sbox_in[j*8 +: 8]),
      .inv_i (sbox_inv),
      .out_o (sbox_out[j*8 +: 8])
    );
  end

  // SBox inputs stay zero outside BUSY so idle lanes never toggle
  always_comb begin
    sbox_in  = '0;
    sbox_inv = 1'b0;
    if (state_q == S_BUSY) begin
      sbox_inv = dec_q;
      for (int unsigned j = 0; j < NSBOX; j++) begin
        sbox_in[j*8 +: 8] = op_q[(32'(beat_q) * NSBOX + j) * 8 +: 8];
      end
    end
  end

  always_comb begin
    res_d = res_q;
    if (state_q == S_BUSY) begin
      for (int unsigned j = 0; j < NSBOX; j++) begin
        res_d[(32'(beat_q) * NSBOX + j) * 8 +: 8] = sbox_out[j*8 +: 8];
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      op_q    <= '0;
      dec_q   <= 1'b0;
      res_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      res_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (valid) begin
            op_q    <= rs1;
            dec_q   <= dec;
            res_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          res_q <= res_d;
          if (beat_q == BW'(BEATS - 1)) begin
            ready_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        S_DONE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          beat_q  <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign rd    = ready_q ? res_q : '0;

endmodule
